// File: rtl/wb_sram_slave.sv
// wb_sram_slave: Wishbone B4 pipelined single-port 32-bit SRAM responder.
// Byte-lane writes, optional wait states, range errors and cycle cancel.
module wb_sram_slave #(
  parameter int    ADDR_WIDTH  = 12,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_adr,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        wb_stall
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW =
    (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_STATES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [31:0]           mem [DEPTH];
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] lat_idx;
  logic                  lat_we;
  logic                  lat_rng;
  logic                  in_range;
  logic                  accept;
  logic                  done;
  logic                  stall;
  logic                  unused_adr;

  assign idx        = wb_adr[ADDR_WIDTH+1:2];
  assign in_range   = (wb_adr[31:ADDR_WIDTH+2] == '0);
  assign unused_adr = ^wb_adr[1:0];
  assign accept     = wb_cyc & wb_stb & ~stall;
  assign done       = (state == BUSY) & wb_cyc
                    & (cnt == CNT_ONE);
  assign wb_stall   = stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Dropping wb_cyc while busy abandons the access silently.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept && WAIT_STATES > 0) state_nxt = BUSY;
      BUSY: if (!wb_cyc || cnt == CNT_ONE) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall = (state == BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      lat_idx <= '0;
      lat_we  <= 1'b0;
      lat_rng <= 1'b0;
    end else if (accept) begin
      cnt     <= CNT_LOAD;
      lat_idx <= idx;
      lat_we  <= wb_we;
      lat_rng <= in_range;
    end else if (state == BUSY) begin
      cnt <= wb_cyc ? cnt - CNT_ONE : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_err   <= 1'b0;
      wb_dat_o <= '0;
    end else if (WAIT_STATES == 0) begin
      wb_ack <= accept & in_range;
      wb_err <= accept & ~in_range;
      if (accept & ~wb_we & in_range)
        wb_dat_o <= mem[idx];
    end else begin
      wb_ack <= done & lat_rng;
      wb_err <= done & ~lat_rng;
      if (done & ~lat_we & lat_rng)
        wb_dat_o <= mem[lat_idx];
    end
  end

  // Writes land at the acceptance edge, even if later cancelled.
  always_ff @(posedge clk) begin
    if (rst_n && accept && wb_we && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (wb_sel[i])
          mem[idx][8*i +: 8] <= wb_dat_i[8*i +: 8];
      end
    end
  end

endmodule
